mem_refill_responder: RTL and testbench

MEM_REFILL_RESPONDER -- requirements
Module: mem_refill_responder

---
 rtl/mem_refill_responder.sv | 137 +++++++++++++
 tb/tb_mem_refill_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_refill_responder.sv
// rtl/mem_refill_responder.sv - line-refill responder: fixed-latency, ascending-order burst from a preloadable backing store
`timescale 1ns/1ps
module mem_refill_responder #(
    parameter int ADR_WIDTH      = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORD_OFFSET    = 2,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int LATENCY        = 3,
    parameter int GAP            = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_cc2mem,
    input  logic [ADR_WIDTH-1:0]      adr_cc2mem,
    output logic                      ack_mem2cc,
    output logic [DATA_WIDTH-1:0]     dat_mem2cc,
    output logic [WORD_OFFSET-1:0]    word_mem2cc,
    output logic                      busy,
    input  logic                      init_we,
    input  logic [MEM_DEPTH_LOG2-1:0] init_adr,
    input  logic [DATA_WIDTH-1:0]     init_dat
);

    localparam int LINE_W  = MEM_DEPTH_LOG2 - WORD_OFFSET;
    localparam int CNT_MAX = (LATENCY > GAP) ? LATENCY : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // Terminal counts; WAIT spans LATENCY-1 cycles because the ack flop adds one more.
    localparam logic [CNT_W-1:0]       LAT_END   = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0]       GAP_END   = CNT_W'((GAP >= 1) ? GAP - 1 : 0);
    localparam logic [WORD_OFFSET-1:0] LAST_BEAT = '1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BEAT, S_GAP, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic [WORD_OFFSET-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [WORD_OFFSET-1:0]  word_q, word_d;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_q [0:(1<<MEM_DEPTH_LOG2)-1];

    // Address bits outside the line index never influence the burst.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{adr_cc2mem[ADR_WIDTH-1:MEM_DEPTH_LOG2+2],
                               adr_cc2mem[WORD_OFFSET+1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            word_q  <= word_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[init_adr] <= init_dat;
        end
    end

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_cc2mem) begin
                    line_d = adr_cc2mem[MEM_DEPTH_LOG2+1:WORD_OFFSET+2];
                    beat_d = '0;
                    cnt_d  = '0;
                    if (LATENCY <= 1) state_d = S_BEAT;
                    else              state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req_cc2mem)           state_d = S_IDLE;
                else if (cnt_q == LAT_END) state_d = S_BEAT;
                else                       cnt_d   = cnt_q + CNT_W'(1);
            end
            S_BEAT: begin
                if (!req_cc2mem) begin
                    state_d = S_IDLE;
                end else if (beat_q == LAST_BEAT) begin
                    state_d = S_DONE;
                end else begin
                    beat_d = beat_q + WORD_OFFSET'(1);
                    cnt_d  = '0;
                    if (GAP == 0) state_d = S_BEAT;
                    else          state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (!req_cc2mem)           state_d = S_IDLE;
                else if (cnt_q == GAP_END) state_d = S_BEAT;
                else                       cnt_d   = cnt_q + CNT_W'(1);
            end
            S_DONE: begin
                if (!req_cc2mem) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack_d  = 1'b0;
        dat_d  = dat_q;
        word_d = word_q;
        busy   = (state_q != S_IDLE);
        // A request arriving in the same cycle as a preload write takes priority.
        mem_we = init_we && (state_q == S_IDLE) && !req_cc2mem;
        if ((state_q == S_BEAT) && req_cc2mem) begin
            ack_d  = 1'b1;
            dat_d  = mem_q[{line_q, beat_q}];
            word_d = beat_q;
        end
    end

    assign ack_mem2cc  = ack_q;
    assign dat_mem2cc  = dat_q;
    assign word_mem2cc = word_q;

endmodule

// File: tb/tb_mem_refill_responder.sv
// tb/tb_mem_refill_responder.sv - scoreboard bench for mem_refill_responder (default and LATENCY=1/GAP=0 instances)
`timescale 1ns/1ps
module tb_mem_refill_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, ack0, busy0, iwe0;
    logic [31:0] adr0, dat0, idat0;
    logic [1:0]  word0;
    logic [9:0]  iadr0;
    logic        req1, ack1, busy1, iwe1;
    logic [31:0] adr1, dat1, idat1;
    logic [1:0]  word1;
    logic [9:0]  iadr1;

    mem_refill_responder u_dut0 (
        .clk(clk), .rst(rst), .req_cc2mem(req0), .adr_cc2mem(adr0),
        .ack_mem2cc(ack0), .dat_mem2cc(dat0), .word_mem2cc(word0), .busy(busy0),
        .init_we(iwe0), .init_adr(iadr0), .init_dat(idat0)
    );

    mem_refill_responder #(.LATENCY(1), .GAP(0)) u_dut1 (
        .clk(clk), .rst(rst), .req_cc2mem(req1), .adr_cc2mem(adr1),
        .ack_mem2cc(ack1), .dat_mem2cc(dat1), .word_mem2cc(word1), .busy(busy1),
        .init_we(iwe1), .init_adr(iadr1), .init_dat(idat1)
    );

    typedef struct {
        int          cyc;
        logic [31:0] dat;
        logic [1:0]  word;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mem0 [int];
    logic [31:0] mem1 [int];
    exp_t        e0, e1;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          n_ack0 = 0;
    int          n_ack1 = 0;
    int          base, n;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (!rst && ack0) begin
            n_ack0++;
            if (q0.size() == 0) begin
                check("ack0_unexpected", 1, 0);
            end else begin
                e0 = q0.pop_front();
                check("ack0_cycle", cyc, e0.cyc);
                check("ack0_dat", dat0, e0.dat);
                check("ack0_word", word0, e0.word);
            end
        end
        if (!rst && ack1) begin
            n_ack1++;
            if (q1.size() == 0) begin
                check("ack1_unexpected", 1, 0);
            end else begin
                e1 = q1.pop_front();
                check("ack1_cycle", cyc, e1.cyc);
                check("ack1_dat", dat1, e1.dat);
                check("ack1_word", word1, e1.word);
            end
        end
    end

    task automatic preload(input bit sel, input int a, input logic [31:0] d);
        @(negedge clk);
        if (!sel) begin
            iwe0 = 1'b1; iadr0 = a[9:0]; idat0 = d; mem0[a] = d;
        end else begin
            iwe1 = 1'b1; iadr1 = a[9:0]; idat1 = d; mem1[a] = d;
        end
        @(negedge clk);
        iwe0 = 1'b0;
        iwe1 = 1'b0;
    endtask

    // Raise the request on the next falling edge; acceptance is the following rising edge.
    task automatic req_on(input bit sel, input logic [31:0] a, input int lat, input int gap,
                          input bit wr_too);
        int t0;
        int ln;
        @(negedge clk);
        t0 = cyc + 1;
        ln = int'(a[11:4]);
        if (!sel) begin
            req0 = 1'b1; adr0 = a;
            if (wr_too) begin
                iwe0 = 1'b1; iadr0 = 10'h342; idat0 = 32'hDEAD;
            end
        end else begin
            req1 = 1'b1; adr1 = a;
        end
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.cyc  = t0 + lat + k * (gap + 1);
            e.word = 2'(k);
            e.dat  = sel ? mem1[ln * 4 + k] : mem0[ln * 4 + k];
            if (!sel) q0.push_back(e);
            else      q1.push_back(e);
        end
    endtask

    task automatic drain(input bit sel, input string tag);
        int w;
        w = 0;
        while ((sel ? q1.size() : q0.size()) != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check(tag, sel ? q1.size() : q0.size(), 0);
    endtask

    task automatic req_off(input bit sel);
        @(negedge clk);
        if (!sel) req0 = 1'b0;
        else      req1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req0 = 0; adr0 = 0; iwe0 = 0; iadr0 = 0; idat0 = 0;
        req1 = 0; adr1 = 0; iwe1 = 0; iadr1 = 0; idat1 = 0;
        repeat (3) @(negedge clk);
        check("rst_ack", ack0, 0);
        check("rst_busy", busy0, 0);
        check("rst_dat", dat0, 0);
        check("rst_word", word0, 0);
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            preload(0, 'h340 + k, 32'hA0 + k);
            preload(0, 'h100 + k, 32'hB0 + k);
            preload(1, 'h340 + k, 32'hC0 + k);
        end

        // Nominal burst, then request held in DONE.
        req_on(0, 32'hFF07BD08, 3, 1, 0);
        drain(0, "nominal_drain");
        check("done_busy", busy0, 1);
        repeat (4) begin
            @(negedge clk);
            check("held_busy", busy0, 1);
        end
        req_off(0);
        @(negedge clk);
        check("idle_busy", busy0, 0);

        req_on(0, 32'hA5552D0C, 3, 1, 0);
        drain(0, "rereq_drain");
        req_off(0);

        // Abort after beat 1.
        base = n_ack0;
        req_on(0, 32'h00000400, 3, 1, 0);
        n = 0;
        while (n_ack0 < base + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_beat1_seen", n_ack0 - base, 2);
        req0 = 1'b0;
        q0.delete();
        @(negedge clk);
        check("abort_busy", busy0, 0);
        repeat (10) @(negedge clk);
        check("abort_ack_count", n_ack0 - base, 2);
        req_on(0, 32'hFF07BD08, 3, 1, 0);
        drain(0, "post_abort_drain");
        req_off(0);

        // Reset in WAIT.
        req_on(0, 32'hFF07BD08, 3, 1, 0);
        @(negedge clk);
        check("wait_busy", busy0, 1);
        rst = 1'b1;
        #1;
        check("rst_wait_ack", ack0, 0);
        check("rst_wait_busy", busy0, 0);
        check("rst_wait_dat", dat0, 0);
        check("rst_wait_word", word0, 0);
        q0.delete();
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Reset in GAP after beat 0.
        base = n_ack0;
        req_on(0, 32'h00000400, 3, 1, 0);
        n = 0;
        while (n_ack0 < base + 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("gap_pre_ack", ack0, 1);
        rst = 1'b1;
        #1;
        check("rst_gap_ack", ack0, 0);
        check("rst_gap_busy", busy0, 0);
        check("rst_gap_dat", dat0, 0);
        check("rst_gap_word", word0, 0);
        q0.delete();
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        req_on(0, 32'hFF07BD08, 3, 1, 0);
        drain(0, "post_rst_drain");
        req_off(0);

        // Preload write while busy is dropped.
        req_on(0, 32'hFF07BD08, 3, 1, 0);
        @(negedge clk);
        iwe0 = 1'b1; iadr0 = 10'h341; idat0 = 32'hDEAD;
        @(negedge clk);
        iwe0 = 1'b0;
        drain(0, "busy_write_drain");
        req_off(0);

        // Preload write colliding with the request is dropped.
        req_on(0, 32'hFF07BD08, 3, 1, 1);
        @(negedge clk);
        iwe0 = 1'b0;
        drain(0, "collide_drain");
        req_off(0);
        req_on(0, 32'hA5552D0C, 3, 1, 0);
        drain(0, "recheck_drain");
        req_off(0);

        // LATENCY=1, GAP=0 instance.
        req_on(1, 32'hFF07BD08, 1, 0, 0);
        drain(1, "fast_drain");
        req_off(1);

        repeat (5) @(negedge clk);
        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
